// File: rtl/cache_miss_scheduler.sv
// Miss-status holding register pool: accepts cache misses, merges duplicate
// addresses, counts down each entry's latency and retires one done entry per cycle.
module cache_miss_scheduler #(
  parameter int MSHR_DEPTH = 4,
  parameter int ADDR_W     = 27,
  parameter int LAT_W      = 5
) (
  input  logic                                clk,
  input  logic                                resetb,
  input  logic                                miss_valid,
  input  logic [ADDR_W-1:0]                   miss_addr,
  input  logic [LAT_W-1:0]                    miss_latency,
  output logic                                miss_ready,
  output logic                                resp_valid,
  output logic [ADDR_W-1:0]                   resp_addr,
  output logic [$clog2(MSHR_DEPTH+1)-1:0]     outstanding,
  output logic                                busy
);

  localparam int CNT_W = $clog2(MSHR_DEPTH + 1);
  localparam int IDX_W = $clog2(MSHR_DEPTH);

  // Handshake: a miss transfers at a rising edge when miss_valid && miss_ready;
  // miss_ready depends only on registered state, the requester holds otherwise.

  typedef enum logic [1:0] {
    POOL_EMPTY   = 2'd0,
    POOL_PARTIAL = 2'd1,
    POOL_FULL    = 2'd2
  } pool_state_e;

  pool_state_e pool_state_q, pool_state_d;

  logic [MSHR_DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]     addr_q [MSHR_DEPTH];
  logic [ADDR_W-1:0]     addr_d [MSHR_DEPTH];
  logic [LAT_W-1:0]      cnt_q  [MSHR_DEPTH];
  logic [LAT_W-1:0]      cnt_d  [MSHR_DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0]     resp_addr_q, resp_addr_d;

  logic                  hit;
  logic                  accept;
  logic                  alloc;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic                  done_found;
  logic [IDX_W-1:0]      done_idx;
  logic [LAT_W-1:0]      lat_eff;

  assign miss_ready  = ~&valid_q;
  assign resp_valid  = resp_valid_q;
  assign resp_addr   = resp_addr_q;
  assign outstanding = count_q;
  assign busy        = (pool_state_q != POOL_EMPTY) || resp_valid_q;

  // Lookup: merge hit, lowest free slot and lowest done slot, all on registered state.
  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == miss_addr)) hit = 1'b1;
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (cnt_q[i] == '0) && !done_found) begin
        done_found = 1'b1;
        done_idx   = IDX_W'(i);
      end
    end
    accept  = miss_valid && miss_ready;
    alloc   = accept && !hit;
    lat_eff = (miss_latency == '0) ? LAT_W'(1) : miss_latency;
  end

  always_comb begin
    valid_d      = valid_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    resp_valid_d = done_found;
    resp_addr_d  = done_found ? addr_q[done_idx] : resp_addr_q;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (done_found && (done_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
      // The allocated slot was invalid, so it never collides with decrement or retire.
      if (alloc && (free_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        addr_d[i]  = miss_addr;
        cnt_d[i]   = lat_eff;
      end
    end
    case ({alloc, done_found})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pool_state_d = pool_state_q;
    if (count_d == '0) begin
      pool_state_d = POOL_EMPTY;
    end else if (count_d == CNT_W'(MSHR_DEPTH)) begin
      pool_state_d = POOL_FULL;
    end else begin
      pool_state_d = POOL_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pool_state_q <= POOL_EMPTY;
      valid_q      <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      pool_state_q <= pool_state_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_scheduler.sv
// Directed bench for cache_miss_scheduler: latency, merge, backpressure,
// contention, mid-flight reset and back-to-back issue.
module tb_cache_miss_scheduler;

  localparam int MSHR_DEPTH = 4;
  localparam int ADDR_W     = 27;
  localparam int LAT_W      = 5;
  localparam int CNT_W      = $clog2(MSHR_DEPTH + 1);

  logic              clk;
  logic              resetb;
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic [LAT_W-1:0]  miss_latency;
  logic              miss_ready;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_addr;
  logic [CNT_W-1:0]  outstanding;
  logic              busy;

  int tests;
  int failed;

  cache_miss_scheduler #(
    .MSHR_DEPTH(MSHR_DEPTH),
    .ADDR_W    (ADDR_W),
    .LAT_W     (LAT_W)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .miss_latency(miss_latency),
    .miss_ready  (miss_ready),
    .resp_valid  (resp_valid),
    .resp_addr   (resp_addr),
    .outstanding (outstanding),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [LAT_W-1:0] l);
    miss_valid   = 1'b1;
    miss_addr    = a;
    miss_latency = l;
    step();
    miss_valid   = 1'b0;
  endtask

  task automatic test_reset();
    resetb     = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    miss_latency = '0;
    #3;
    tests++; if (miss_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %0b exp 1", miss_ready); end
    tests++; if (resp_valid !== 1'b0) begin failed++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
    tests++; if (resp_addr !== '0) begin failed++; $display("FAIL reset_resp_addr got %0h exp 0", resp_addr); end
    tests++; if (outstanding !== '0) begin failed++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0b exp 0", busy); end
    step();
    resetb = 1'b1;
    step();
  endtask

  task automatic test_single();
    issue(27'h05, 5'd3);
    tests++; if (outstanding !== 3'd1) begin failed++; $display("FAIL single_out_alloc got %0d exp 1", outstanding); end
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++; if (resp_valid !== (k == 4)) begin failed++; $display("FAIL single_resp k=%0d got %0b exp %0b", k, resp_valid, (k == 4)); end
      if (k == 4) begin
        tests++; if (resp_addr !== 27'h05) begin failed++; $display("FAIL single_addr got %0h exp 5", resp_addr); end
      end
      tests++; if (outstanding !== ((k < 4) ? 3'd1 : 3'd0)) begin failed++; $display("FAIL single_out k=%0d got %0d", k, outstanding); end
    end
  endtask

  task automatic test_zero_latency();
    issue(27'h10, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      tests++; if (resp_valid !== (k == 2)) begin failed++; $display("FAIL zero_lat_resp k=%0d got %0b exp %0b", k, resp_valid, (k == 2)); end
      if (k == 2) begin
        tests++; if (resp_addr !== 27'h10) begin failed++; $display("FAIL zero_lat_addr got %0h exp 10", resp_addr); end
      end
    end
  endtask

  task automatic test_merge();
    int pulses;
    pulses = 0;
    issue(27'h22, 5'd5);
    step();
    issue(27'h22, 5'd2);
    tests++; if (outstanding !== 3'd1) begin failed++; $display("FAIL merge_out got %0d exp 1", outstanding); end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (resp_valid === 1'b1) begin
        pulses++;
        tests++; if (k != 4) begin failed++; $display("FAIL merge_resp_time got k=%0d exp k=4", k); end
        tests++; if (resp_addr !== 27'h22) begin failed++; $display("FAIL merge_addr got %0h exp 22", resp_addr); end
      end
      if (k < 4) begin
        tests++; if (outstanding !== 3'd1) begin failed++; $display("FAIL merge_hold k=%0d got %0d exp 1", k, outstanding); end
      end
    end
    tests++; if (pulses != 1) begin failed++; $display("FAIL merge_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_full_backpressure();
    for (int a = 1; a <= 4; a++) issue(ADDR_W'(a), 5'd8);
    tests++; if (outstanding !== 3'd4) begin failed++; $display("FAIL full_out got %0d exp 4", outstanding); end
    tests++; if (miss_ready !== 1'b0) begin failed++; $display("FAIL full_ready got %0b exp 0", miss_ready); end
    miss_valid   = 1'b1;
    miss_addr    = 27'h5;
    miss_latency = 5'd8;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests++; if (miss_ready !== 1'b0 || outstanding !== 3'd4 || resp_valid !== 1'b0) begin
        failed++; $display("FAIL full_hold k=%0d ready=%0b out=%0d resp=%0b exp 0/4/0", k, miss_ready, outstanding, resp_valid);
      end
    end
    step();
    tests++; if (resp_valid !== 1'b1 || resp_addr !== 27'h1) begin failed++; $display("FAIL full_first_resp got %0b/%0h exp 1/1", resp_valid, resp_addr); end
    tests++; if (miss_ready !== 1'b1 || outstanding !== 3'd3) begin failed++; $display("FAIL full_free got ready=%0b out=%0d exp 1/3", miss_ready, outstanding); end
    step();
    miss_valid = 1'b0;
    tests++; if (resp_valid !== 1'b1 || resp_addr !== 27'h2) begin failed++; $display("FAIL full_second_resp got %0b/%0h exp 1/2", resp_valid, resp_addr); end
    tests++; if (outstanding !== 3'd3) begin failed++; $display("FAIL full_alloc_retire got %0d exp 3", outstanding); end
    step();
    tests++; if (resp_addr !== 27'h3 || resp_valid !== 1'b1) begin failed++; $display("FAIL full_third_resp got %0b/%0h exp 1/3", resp_valid, resp_addr); end
    step();
    tests++; if (resp_addr !== 27'h4 || outstanding !== 3'd1) begin failed++; $display("FAIL full_fourth got addr=%0h out=%0d exp 4/1", resp_addr, outstanding); end
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++; if (resp_valid !== (k == 7)) begin failed++; $display("FAIL full_fifth_resp k=%0d got %0b exp %0b", k, resp_valid, (k == 7)); end
      if (k == 7) begin
        tests++; if (resp_addr !== 27'h5) begin failed++; $display("FAIL full_fifth_addr got %0h exp 5", resp_addr); end
      end
    end
    tests++; if (outstanding !== 3'd0) begin failed++; $display("FAIL full_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_contention();
    issue(27'hA, 5'd4);
    issue(27'hB, 5'd3);
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++; if (resp_valid !== (k == 4 || k == 5)) begin failed++; $display("FAIL contention_resp k=%0d got %0b", k, resp_valid); end
      if (k == 4) begin
        tests++; if (resp_addr !== 27'hA) begin failed++; $display("FAIL contention_first got %0h exp a", resp_addr); end
      end
      if (k == 5) begin
        tests++; if (resp_addr !== 27'hB) begin failed++; $display("FAIL contention_second got %0h exp b", resp_addr); end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    int pulses;
    pulses = 0;
    issue(27'h30, 5'd10);
    issue(27'h31, 5'd10);
    issue(27'h32, 5'd10);
    tests++; if (outstanding !== 3'd3) begin failed++; $display("FAIL rst_mid_out got %0d exp 3", outstanding); end
    resetb = 1'b0;
    #2;
    tests++; if (outstanding !== 3'd0 || miss_ready !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL rst_mid_clear out=%0d ready=%0b busy=%0b exp 0/1/0", outstanding, miss_ready, busy);
    end
    step();
    resetb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (resp_valid === 1'b1) pulses++;
    end
    tests++; if (pulses != 0) begin failed++; $display("FAIL rst_mid_pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_back_to_back();
    miss_valid   = 1'b1;
    miss_latency = 5'd2;
    for (int a = 0; a < 3; a++) begin
      miss_addr = ADDR_W'(27'h40 + a);
      step();
    end
    miss_valid = 1'b0;
    tests++; if (outstanding !== 3'd3) begin failed++; $display("FAIL b2b_out got %0d exp 3", outstanding); end
    for (int k = 1; k <= 4; k++) begin
      step();
      tests++; if (resp_valid !== (k <= 3)) begin failed++; $display("FAIL b2b_resp k=%0d got %0b", k, resp_valid); end
      if (k <= 3) begin
        tests++; if (resp_addr !== ADDR_W'(27'h3F + k)) begin failed++; $display("FAIL b2b_addr k=%0d got %0h", k, resp_addr); end
      end
      tests++; if (busy !== (k <= 3)) begin failed++; $display("FAIL b2b_busy k=%0d got %0b", k, busy); end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_single();
    test_zero_latency();
    test_merge();
    test_full_backpressure();
    test_contention();
    test_reset_mid_flight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
